// File: rtl/mult_seq_64.sv
// mult_seq_64: iterative shift-add signed multiplier. It produces one
// result every WIDTH+2 cycles and handles one operation at a time.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     request; sampled only in IDLE or DONE
//   a, b      two's-complement operands, captured when start is accepted
//   high_sel  0: low WIDTH bits of the product, 1: high WIDTH bits
//   busy      high while the operation is in CALC or FIX
//   done      one-cycle pulse in DONE
//   result    registered; updated only on the FIX->DONE edge
module mult_seq_64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             high_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic                 hsel_q, hsel_d;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   prod;

   // Unsigned magnitudes: negating 0x80..0 gives 0x80..0, which read as
   // unsigned is exactly 2^(WIDTH-1).
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;
   assign prod  = sign_q ? -acc_q : acc_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      hsel_d   = hsel_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StCalc;
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, mag_a};
               mplier_d = mag_b;
               cnt_d    = '0;
               sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
               hsel_d   = high_sel;
            end else begin
               state_d = StIdle;
            end
         end
         StCalc: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            result_d = hsel_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            state_d  = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         hsel_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         hsel_q   <= hsel_d;
      end
   end

   assign busy   = (state_q == StCalc) || (state_q == StFix);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_mult_seq_64.sv
// tb_mult_seq_64: directed test of mult_seq_64. Stimulus pushes each
// expected result into a queue; a monitor pops and compares on every done.
module tb_mult_seq_64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        high_sel = 1'b0;
   logic        busy, done;
   logic [63:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   mult_seq_64 #(.WIDTH(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .high_sel (high_sel),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("result at done", result, e);
         end
      end
   end

   // Called #1 after the accepting edge; returns at the negedge where done is seen.
   task automatic measure(input string name, input logic hold_en, input logic [63:0] hold_val);
      int lat;
      int bcnt;
      int hold_bad;
      lat = -1;
      bcnt = 0;
      hold_bad = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (busy) bcnt++;
         if (hold_en && result !== hold_val) hold_bad++;
      end
      chk($sformatf("%s latency", name), 64'(lat), 64'd65);
      chk($sformatf("%s busy cycles", name), 64'(bcnt), 64'd65);
      if (hold_en) chk($sformatf("%s result hold", name), 64'(hold_bad), 64'd0);
      chk($sformatf("%s busy in done", name), {63'd0, busy}, 64'd0);
   endtask

   task automatic run_op(input string name, input logic [63:0] av, input logic [63:0] bv,
                         input logic hs, input logic [63:0] exp);
      start = 1'b1;
      a = av;
      b = bv;
      high_sel = hs;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~av;
      b = ~bv;
      high_sel = ~hs;
      measure(name, 1'b0, '0);
      @(negedge clk);
      chk($sformatf("%s done low after", name), {63'd0, done}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset result", result, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("3*5 lo", 64'd3, 64'd5, 1'b0, 64'h000000000000000F);
      run_op("-3*5 lo", 64'hFFFFFFFFFFFFFFFD, 64'd5, 1'b0, 64'hFFFFFFFFFFFFFFF1);
      run_op("-3*5 hi", 64'hFFFFFFFFFFFFFFFD, 64'd5, 1'b1, 64'hFFFFFFFFFFFFFFFF);
      run_op("max*max hi", 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1'b1,
             64'h3FFFFFFFFFFFFFFF);
      run_op("min*min hi", 64'h8000000000000000, 64'h8000000000000000, 1'b1,
             64'h4000000000000000);
      run_op("min*min lo", 64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'd0);
      run_op("-1*-1 lo", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'd1);
      run_op("-1*-1 hi", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0);
      run_op("x*16 hi", 64'h123456789ABCDEF0, 64'd16, 1'b1, 64'd1);
      run_op("x*16 lo", 64'h123456789ABCDEF0, 64'd16, 1'b0, 64'h23456789ABCDEF00);

      // Start ignored while busy, then back-to-back start from DONE.
      start = 1'b1;
      a = 64'd2;
      b = 64'd7;
      high_sel = 1'b0;
      exp_q.push_back(64'd14);
      @(posedge clk);
      #1;
      start = 1'b0;
      fork
         measure("2*7", 1'b0, '0);
         begin
            repeat (10) @(posedge clk);
            #1;
            start = 1'b1;
            a = 64'd9;
            b = 64'd9;
            high_sel = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            a = 64'h55;
         end
      join
      start = 1'b1;
      a = 64'd4;
      b = 64'd4;
      high_sel = 1'b0;
      exp_q.push_back(64'd16);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy after start in done", {63'd0, busy}, 64'd1);
      measure("4*4", 1'b1, 64'd14);
      @(negedge clk);
      chk("4*4 done low after", {63'd0, done}, 64'd0);

      // Reset mid-operation aborts it.
      start = 1'b1;
      a = 64'd6;
      b = 64'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort busy", {63'd0, busy}, 64'd0);
      chk("abort done", {63'd0, done}, 64'd0);
      chk("abort result", result, 64'd0);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
         end
         chk("abort no activity", 64'(seen), 64'd0);
      end

      run_op("0*x lo", 64'd0, 64'h123456789ABCDEF0, 1'b0, 64'd0);
      run_op("0*x hi", 64'd0, 64'h123456789ABCDEF0, 1'b1, 64'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_seq_64.md
Name: mult_seq_64

Overview:
- Iterative shift-add signed multiplier for the execute stage.
- Its registered result drives one input of the 8:1 ALU/result-select mux, covering the MUL and SMULH operations.
- Start/busy/done handshake. The control unit stalls the pipeline while `busy` is high.
- One 64-bit operation in flight at a time.

Parameters:
- WIDTH, 64, operand and result width. Iteration count equals WIDTH.

Ports:
- clk       input   1      clock, all state updates on rising edge.
- reset     input   1      synchronous, active-high.
- start     input   1      request; sampled only when not busy.
- a         input   WIDTH  multiplicand, two's complement; captured at accepted start.
- b         input   WIDTH  multiplier, two's complement; captured at accepted start.
- high_sel  input   1      0 = low WIDTH bits of product (MUL); 1 = high WIDTH bits (SMULH); captured at accepted start.
- busy      output  1      high in CALC and FIX.
- done      output  1      one-cycle pulse, high in DONE.
- result    output  WIDTH  registered; updates only on the FIX→DONE edge and holds until the next update.

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`reset`). Reset dominates every other input on any edge.
- Reset values: state=IDLE, busy=0, done=0, result=0. Internal accumulator, multiplier register and counter are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at an edge → CALC.
  - On that edge, capture |a| and |b| as unsigned magnitudes, sign = a[WIDTH-1]^b[WIDTH-1], and high_sel.
  - Clear the 2·WIDTH accumulator. Set counter = 0.
- CALC, one iteration per edge:
  - If multiplier LSB=1, add the shifted multiplicand into the accumulator.
  - Shift the multiplier right by 1 and the multiplicand left by 1.
  - Increment the counter.
  - The edge with counter = WIDTH-1 performs the final iteration and moves to FIX.
  - CALC lasts exactly WIDTH cycles.
- FIX, one cycle:
  - The edge two's-complement negates the 2·WIDTH product if sign=1.
  - It loads result with product[WIDTH-1:0] when high_sel=0, or product[2·WIDTH-1:WIDTH] when high_sel=1.
  - Moves to DONE.
- DONE:
  - done=1, busy=0.
  - Next edge: start=1 is accepted exactly as in IDLE (→ CALC). Otherwise → IDLE.
- Latency:
  - Start accepted at edge E0.
  - done is high in the cycle after edge E0+WIDTH+1, i.e. done rises WIDTH+1 = 65 cycles after E0.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic rules:
  - Full signed 2·WIDTH-bit product.
  - The most negative operand (0x8000…0) has magnitude 2^(WIDTH-1) and is handled correctly by unsigned magnitudes.
  - No overflow flag. The low half is identical for signed and unsigned interpretation.
- Boundary conditions:
  - start while busy=1: ignored; the current operation is unaffected.
  - a, b, high_sel changing during busy: ignored.
  - Zero operand: runs the full WIDTH cycles (no early exit) and yields 0.
  - Reset in CALC/FIX/DONE: next cycle is IDLE with busy=0 and done=0. result returns to 0, no done pulse, and the aborted operation is lost.
  - result is never X after reset and never changes except at the FIX edge or on reset.

Test Plan:
- Reset, then a=3, b=5, high_sel=0, start for 1 cycle → busy=1 for 65 cycles; done pulses 65 cycles after start edge; result=0x000000000000000F; done low next cycle.
- a=-3 (0xFFFFFFFFFFFFFFFD), b=5, high_sel=0 → result=0xFFFFFFFFFFFFFFF1. Repeat with high_sel=1 → result=0xFFFFFFFFFFFFFFFF.
- a=b=0x7FFFFFFFFFFFFFFF, high_sel=1 → 0x3FFFFFFFFFFFFFFF. a=b=0x8000000000000000, high_sel=1 → 0x4000000000000000; high_sel=0 → 0.
- Start a=2, b=7; at cycle 10 pulse start with a=9, b=9 and change a → result=14 at done, with no second operation begun. Then hold start=1 through the DONE cycle with a=4, b=4 → new op accepted immediately; result=16 after another 65 cycles; result holds 14 until then.
- Start a=6, b=6; assert reset at cycle 30 for 1 cycle → busy=0, done=0, result=0 on next cycle; no done pulse ever appears for that op.
- a=0, b=0x123456789ABCDEF0, high_sel=0 and high_sel=1 → both result=0 after the full 65-cycle latency.
